// File: rtl/ft_out_arbiter_pkg.sv
// Shared types and header-field layout for the FT2232 OUT-path arbiter.
package ft_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        READ,
        DRAIN
    } state_t;

    localparam int HDR_CH_MSB  = 7;
    localparam int HDR_CH_LSB  = 6;
    localparam int HDR_LEN_MSB = 5;
    localparam int HDR_LEN_LSB = 0;

    localparam int MAX_BURST_LIMIT = 63;
    localparam int MAX_CH_LIMIT    = 4;

    function automatic logic [7:0] hdr_pack(input logic [1:0] ch, input logic [5:0] len);
        logic [7:0] h;
        h = '0;
        h[HDR_CH_MSB:HDR_CH_LSB]   = ch;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/ft_out_arbiter_if.sv
// Source-FIFO bank and OUT FIFO write side as seen by the arbiter (master) and its environment (slave).
interface ft_out_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int LVL_W  = 10
);
    logic [NUM_CH-1:0]       ch_enable_i;
    logic [NUM_CH*LVL_W-1:0] src_level_i;
    logic [NUM_CH-1:0]       src_rd_en_o;
    logic [NUM_CH*8-1:0]     src_data_i;
    logic                    wr_out_fifo_en_o;
    logic [7:0]              wr_out_fifo_data_o;
    logic                    wr_out_fifo_full_i;
    logic                    wr_out_fifo_afull_i;

    modport master (
        input  ch_enable_i, src_level_i, src_data_i, wr_out_fifo_full_i, wr_out_fifo_afull_i,
        output src_rd_en_o, wr_out_fifo_en_o, wr_out_fifo_data_o
    );

    modport slave (
        output ch_enable_i, src_level_i, src_data_i, wr_out_fifo_full_i, wr_out_fifo_afull_i,
        input  src_rd_en_o, wr_out_fifo_en_o, wr_out_fifo_data_o
    );
endinterface

// File: rtl/ft_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible channel strictly after the last grant.
module ft_rr_pick
    import ft_fifo_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [1:0]        last,
    output logic              valid,
    output logic [1:0]        idx
);

    logic [MAX_CH_LIMIT-1:0] elig_pad;
    logic [1:0]              cand;

    always_comb begin
        elig_pad                 = '0;
        elig_pad[NUM_CH-1:0]     = eligible;
        valid                    = 1'b0;
        idx                      = '0;
        cand                     = '0;
        // Walk from farthest to nearest so the nearest eligible channel wins.
        for (int unsigned off = NUM_CH; off >= 1; off--) begin
            cand = 2'((32'(last) + off) % NUM_CH);
            if (elig_pad[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ft_out_arbiter.sv
// Round-robin arbiter framing source byte streams into header+payload bursts on the OUT FIFO.
module ft_out_arbiter
    import ft_fifo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int LVL_W     = 10,
    parameter int MAX_BURST = 63
) (
    input  logic                clk_i,
    input  logic                reset_i,
    ft_out_arbiter_if.master    bus,
    output logic                busy_o,
    output logic [1:0]          cur_ch_o
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH_LIMIT) begin : g_bad_num_ch
        $error("ft_out_arbiter: NUM_CH must be 1..4");
    end
    if (MAX_BURST < 1 || MAX_BURST > MAX_BURST_LIMIT) begin : g_bad_max_burst
        $error("ft_out_arbiter: MAX_BURST must be 1..63");
    end
    if (LVL_W < 1 || LVL_W > 32) begin : g_bad_lvl_w
        $error("ft_out_arbiter: LVL_W must be 1..32");
    end

    state_t            state, state_nx;
    logic [1:0]        ch, last;
    logic [5:0]        len, cnt;
    logic              rd_d;
    logic              pay_en;
    logic [7:0]        pay_data;
    logic              ok;
    logic              hdr_fire, rd_fire;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] ch_onehot;
    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic [LVL_W-1:0]  pick_level;
    logic [5:0]        pick_len;
    logic [7:0]        sel_data;

    assign ok = ~bus.wr_out_fifo_full_i & ~bus.wr_out_fifo_afull_i;

    always_comb begin
        elig       = '0;
        pick_level = '0;
        sel_data   = '0;
        ch_onehot  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            elig[n]      = bus.ch_enable_i[n] & (bus.src_level_i[n*LVL_W +: LVL_W] != '0);
            ch_onehot[n] = (ch == 2'(n));
            if (pick_idx == 2'(n))
                pick_level = bus.src_level_i[n*LVL_W +: LVL_W];
            if (ch == 2'(n))
                sel_data = bus.src_data_i[n*8 +: 8];
        end
        pick_len = (32'(pick_level) > MAX_BURST) ? 6'(MAX_BURST) : 6'(pick_level);
    end

    ft_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .eligible (elig),
        .last     (last),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nx = HEADER;
            HEADER:  if (ok) state_nx = READ;
            READ:    if (rd_fire && cnt == 6'd1) state_nx = DRAIN;
            // Leave once the last strobed byte is the one being written this cycle.
            DRAIN:   if (!rd_d) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        hdr_fire               = (state == HEADER) && ok;
        rd_fire                = (state == READ) && (cnt != '0) && ok;
        bus.src_rd_en_o        = rd_fire ? ch_onehot : '0;
        bus.wr_out_fifo_en_o   = hdr_fire || pay_en;
        bus.wr_out_fifo_data_o = hdr_fire ? hdr_pack(ch, len) : pay_data;
        busy_o                 = (state != IDLE);
        cur_ch_o               = ch;
    end

    // Two-stage payload pipe: strobe -> source data valid (rd_d) -> registered write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ch       <= '0;
            len      <= '0;
            cnt      <= '0;
            last     <= 2'(NUM_CH - 1);
            rd_d     <= 1'b0;
            pay_en   <= 1'b0;
            pay_data <= '0;
        end else begin
            rd_d   <= rd_fire;
            pay_en <= rd_d;
            if (rd_d)
                pay_data <= sel_data;
            if (state == IDLE && pick_valid) begin
                ch  <= pick_idx;
                len <= pick_len;
            end
            if (hdr_fire)
                cnt <= len;
            else if (rd_fire)
                cnt <= cnt - 6'd1;
            if (state == DRAIN && !rd_d)
                last <= ch;
        end
    end

endmodule

// File: tb/tb_ft_out_arbiter.sv
// Scoreboard bench for ft_out_arbiter: stimulus queues expected OUT FIFO bytes, a monitor pops and compares.
module tb_ft_out_arbiter;
    localparam int NUM_CH    = 4;
    localparam int LVL_W     = 10;
    localparam int MAX_BURST = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [1:0] cur_ch;

    ft_out_arbiter_if #(.NUM_CH(NUM_CH), .LVL_W(LVL_W)) bus ();

    ft_out_arbiter #(
        .NUM_CH    (NUM_CH),
        .LVL_W     (LVL_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .bus      (bus),
        .busy_o   (busy),
        .cur_ch_o (cur_ch)
    );

    always #5 clk = ~clk;

    logic [3:0]  en;
    logic        full, afull;
    int          base  [4];
    int          start [4];
    int          rd_cnt[4] = '{0, 0, 0, 0};
    int          s0    [4];
    logic [3:0]  seen = '0;
    logic [39:0] lvl_bus;
    logic [31:0] dat_bus;
    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    int          total = 0;
    int          bad   = 0;
    int          busy_cyc = 0;
    int          wr_cnt   = 0;
    int          afl_wr   = 0;

    // Source model: level = base - bytes read; data for the k-th read is start + k - 1.
    always_comb begin
        lvl_bus = '0;
        dat_bus = '0;
        for (int n = 0; n < 4; n++) begin
            lvl_bus[n*10 +: 10] = 10'(base[n] - rd_cnt[n]);
            dat_bus[n*8 +: 8]   = 8'(start[n] + rd_cnt[n] - 1);
        end
    end

    assign bus.ch_enable_i         = en;
    assign bus.src_level_i         = lvl_bus;
    assign bus.src_data_i          = dat_bus;
    assign bus.wr_out_fifo_full_i  = full;
    assign bus.wr_out_fifo_afull_i = afull;

    always @(negedge clk) seen = bus.src_rd_en_o;

    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 4; n++)
            if (seen[n]) rd_cnt[n]++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cyc++;
            if (bus.wr_out_fifo_en_o) begin
                wr_cnt++;
                if (afull) afl_wr++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_extra got=%02h want=none", bus.wr_out_fifo_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.wr_out_fifo_data_o !== e) begin
                        bad++;
                        $display("FAIL wr_data got=%02h want=%02h", bus.wr_out_fifo_data_o, e);
                    end
                end
            end
            if (full) begin
                total++;
                if (bus.wr_out_fifo_en_o !== 1'b0) begin
                    bad++;
                    $display("FAIL wr_while_full got=%b want=0", bus.wr_out_fifo_en_o);
                end
            end
            if (afull) begin
                total++;
                if (bus.src_rd_en_o !== 4'b0000) begin
                    bad++;
                    $display("FAIL rd_while_afull got=%b want=0000", bus.src_rd_en_o);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_src(input int n, input logic e_bit, input int level, input int first);
        en[n]    = e_bit;
        base[n]  = level + rd_cnt[n];
        start[n] = first - rd_cnt[n];
    endtask

    task automatic push_burst(input logic [1:0] ch, input int len, input int first);
        exp_q.push_back({ch, 6'(len)});
        for (int i = 0; i < len; i++) exp_q.push_back(8'(first + i));
    endtask

    task automatic snap();
        for (int n = 0; n < 4; n++) s0[n] = rd_cnt[n];
    endtask

    function automatic int strb(input int n);
        return rd_cnt[n] - s0[n];
    endfunction

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            step();
            k++;
        end
        chk({name, "_done"}, int'(exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic wait_strobe(input string name, input int n, input int cnt, input int budget);
        int k = 0;
        while (strb(n) < cnt && k < budget) begin
            step();
            k++;
        end
        chk({name, "_strobes_seen"}, int'(strb(n) >= cnt), 1);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        full  = 1'b0;
        afull = 1'b0;
        for (int n = 0; n < 4; n++) set_src(n, 1'b0, 0, 0);
        repeat (2) step();
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    int b0, w0, a0, s_at;

    initial begin
        en    = '0;
        full  = 1'b0;
        afull = 1'b0;
        for (int n = 0; n < 4; n++) begin
            base[n]  = 0;
            start[n] = 0;
        end
        rst = 1'b1;
        #7;
        chk("rst_wr_en", int'(bus.wr_out_fifo_en_o), 0);
        chk("rst_wr_data", int'(bus.wr_out_fifo_data_o), 0);
        chk("rst_rd_en", int'(bus.src_rd_en_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur_ch", int'(cur_ch), 0);
        do_reset();

        // 1: single channel, short burst
        snap();
        b0 = busy_cyc;
        set_src(2, 1'b1, 5, 8'h10);
        push_burst(2'd2, 5, 8'h10);
        wait_done("t1", 100);
        chk("t1_ch2_strobes", strb(2), 5);
        chk("t1_other_strobes", strb(0) + strb(1) + strb(3), 0);
        chk("t1_busy_cycles", busy_cyc - b0, 8);

        // 2: two channels, bursts capped at MAX_BURST, alternating
        do_reset();
        snap();
        w0 = wr_cnt;
        set_src(0, 1'b1, 100, 8'h00);
        set_src(1, 1'b1, 100, 8'h80);
        push_burst(2'd0, 63, 8'h00);
        push_burst(2'd1, 63, 8'h80);
        push_burst(2'd0, 37, 8'h3F);
        push_burst(2'd1, 37, 8'hBF);
        wait_done("t2", 800);
        chk("t2_payload_reads", strb(0) + strb(1), 200);
        chk("t2_writes", wr_cnt - w0, 204);

        // 3: afull stall mid-burst, with full asserted inside the window
        do_reset();
        snap();
        set_src(0, 1'b1, 20, 8'h40);
        push_burst(2'd0, 20, 8'h40);
        wait_strobe("t3", 0, 5, 100);
        a0    = afl_wr;
        s_at  = strb(0);
        afull = 1'b1;
        repeat (4) step();
        full = 1'b1;
        repeat (4) step();
        full = 1'b0;
        repeat (2) step();
        chk("t3_reads_in_afull", strb(0) - s_at, 0);
        chk("t3_writes_after_afull_le2", int'((afl_wr - a0) <= 2), 1);
        afull = 1'b0;
        wait_done("t3", 200);
        chk("t3_ch0_strobes", strb(0), 20);

        // 4: disabled channel ignored; header held while afull
        do_reset();
        snap();
        afull = 1'b1;
        set_src(1, 1'b0, 50, 8'h50);
        set_src(3, 1'b1, 3, 8'h30);
        push_burst(2'd3, 3, 8'h30);
        repeat (5) step();
        chk("t4_busy_in_header", int'(busy), 1);
        chk("t4_cur_ch", int'(cur_ch), 3);
        chk("t4_no_write_stalled", exp_q.size(), 4);
        afull = 1'b0;
        wait_done("t4a", 100);
        chk("t4_ch1_not_strobed", strb(1), 0);
        chk("t4_ch3_strobes", strb(3), 3);
        push_burst(2'd1, 50, 8'h50);
        en[1] = 1'b1;
        wait_done("t4b", 300);
        chk("t4_ch1_strobes", strb(1), 50);

        // 5: reset during READ abandons the burst and restores ch0 priority
        do_reset();
        set_src(0, 1'b1, 2, 8'h01);
        push_burst(2'd0, 2, 8'h01);
        wait_done("t5a", 100);
        snap();
        set_src(0, 1'b1, 40, 8'h03);
        push_burst(2'd0, 40, 8'h03);
        wait_strobe("t5", 0, 10, 100);
        rst = 1'b1;
        #1;
        chk("t5_rst_rd_en", int'(bus.src_rd_en_o), 0);
        chk("t5_rst_wr_en", int'(bus.wr_out_fifo_en_o), 0);
        chk("t5_rst_busy", int'(busy), 0);
        exp_q.delete();
        set_src(0, 1'b1, 4, 8'hA0);
        set_src(1, 1'b1, 4, 8'hB0);
        push_burst(2'd0, 4, 8'hA0);
        push_burst(2'd1, 4, 8'hB0);
        repeat (2) step();
        rst = 1'b0;
        wait_done("t5b", 100);

        // 6: all enabled, all empty -> idle
        do_reset();
        snap();
        b0 = busy_cyc;
        w0 = wr_cnt;
        for (int n = 0; n < 4; n++) set_src(n, 1'b1, 0, 0);
        repeat (100) step();
        chk("t6_busy_cycles", busy_cyc - b0, 0);
        chk("t6_writes", wr_cnt - w0, 0);
        chk("t6_strobes", strb(0) + strb(1) + strb(2) + strb(3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
